// File: rtl/tank_pkg.sv
// tank_pkg: types and constants shared by the tank, the bullet controller and
// the grid helpers.
//   - DIR_*          : 2-bit facing/travel codes (UP, DOWN, LEFT, RIGHT)
//   - DIR_STAND      : 3-bit joystick "no move" code used by the tank input path
//   - GRID_X/Y_MAX   : default playfield limits (40x30 grid of 16-px tiles)
//   - bullet_state_e : bullet controller states
package tank_pkg;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  // Only meaningful on the 3-bit joystick path; a bullet always has a heading.
  localparam logic [2:0] DIR_STAND = 3'd4;

  localparam int GRID_X_MAX = 39;
  localparam int GRID_Y_MAX = 29;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_e;
endpackage

// File: rtl/tank_bullet_if.sv
// tank_bullet_if: groups the bullet controller's frame/fire/tank inputs and
// its bullet outputs.
//   slave  : the bullet controller (consumes tank/fire/hit, drives bullet_*)
//   master : the environment (tank block, Game logic, bench)
interface tank_bullet_if;
  logic       frame_tick;
  logic       fire;
  logic [5:0] tank_x;
  logic [5:0] tank_y;
  logic [1:0] tank_dir;
  logic       hit;
  logic       bullet_valid;
  logic [5:0] bullet_x;
  logic [5:0] bullet_y;
  logic [1:0] bullet_dir;
  logic       ready;

  modport slave (
    input  frame_tick, fire, tank_x, tank_y, tank_dir, hit,
    output bullet_valid, bullet_x, bullet_y, bullet_dir, ready
  );

  modport master (
    output frame_tick, fire, tank_x, tank_y, tank_dir, hit,
    input  bullet_valid, bullet_x, bullet_y, bullet_dir, ready
  );
endinterface

// File: rtl/grid_step.sv
// grid_step: combinational one-cell move on the playfield grid.
//   x, y, dir : current cell and heading
//   nx, ny    : neighbour cell in dir (equals x,y when off_grid)
//   off_grid  : the neighbour would leave [0..X_MAX] x [0..Y_MAX]
// The bound test is done before the +/-1, so the 6-bit math never wraps.
module grid_step import tank_pkg::*; #(
  parameter int X_MAX = GRID_X_MAX,
  parameter int Y_MAX = GRID_Y_MAX
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic [1:0] dir,
  output logic [5:0] nx,
  output logic [5:0] ny,
  output logic       off_grid
);
  always_comb begin
    nx       = x;
    ny       = y;
    off_grid = 1'b0;
    case (dir)
      DIR_UP:    if (y == 6'd0)         off_grid = 1'b1; else ny = y - 6'd1;
      DIR_DOWN:  if (y >= 6'(Y_MAX))    off_grid = 1'b1; else ny = y + 6'd1;
      DIR_LEFT:  if (x == 6'd0)         off_grid = 1'b1; else nx = x - 6'd1;
      default:   if (x >= 6'(X_MAX))    off_grid = 1'b1; else nx = x + 6'd1;
    endcase
  end
endmodule

// File: rtl/tank_bullet.sv
// tank_bullet: single-bullet controller downstream of the tank block.
//   clk, rst          : system clock, synchronous active-high reset
//   bif.frame_tick    : one-cycle frame strobe (paces spawn, flight, cooldown)
//   bif.fire          : fire request, pulse or level, latched until next tick
//   bif.tank_x/y/dir  : tank cell and facing, sampled only at spawn
//   bif.hit           : collision report from Game, honoured only in flight
//   bif.bullet_*      : registered bullet cell/heading/valid
//   bif.ready         : registered, high while a fire would be accepted
module tank_bullet import tank_pkg::*; #(
  parameter int X_MAX           = GRID_X_MAX,
  parameter int Y_MAX           = GRID_Y_MAX,
  parameter int STEP_FRAMES     = 2,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst,
  tank_bullet_if.slave  bif
);
  localparam int SCW = $clog2(STEP_FRAMES + 1);
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);

  bullet_state_e  state_q, state_d;
  logic [SCW-1:0] step_cnt_q, step_cnt_d;
  logic [CDW-1:0] cd_cnt_q, cd_cnt_d;
  logic           fire_pending_q, fire_pending_d;
  logic           valid_q, valid_d;
  logic [5:0]     x_q, x_d, y_q, y_d;
  logic [1:0]     dir_q, dir_d;
  logic           ready_q, ready_d;

  logic [5:0] sp_x, sp_y, fl_x, fl_y;
  logic       sp_off, fl_off, pend;

  grid_step #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_spawn (
    .x(bif.tank_x), .y(bif.tank_y), .dir(bif.tank_dir),
    .nx(sp_x), .ny(sp_y), .off_grid(sp_off)
  );

  grid_step #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_fly (
    .x(x_q), .y(y_q), .dir(dir_q),
    .nx(fl_x), .ny(fl_y), .off_grid(fl_off)
  );

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    // A fire in the tick cycle itself still counts for that tick; every tick
    // then clears the latch whether or not it was consumed.
    pend           = fire_pending_q | bif.fire;
    fire_pending_d = bif.frame_tick ? 1'b0 : pend;

    case (state_q)
      IDLE: begin
        if (bif.frame_tick && pend && !sp_off) begin
          x_d        = sp_x;
          y_d        = sp_y;
          dir_d      = bif.tank_dir;
          valid_d    = 1'b1;
          step_cnt_d = '0;
          state_d    = FLYING;
        end
      end
      FLYING: begin
        if (bif.hit) begin
          valid_d  = 1'b0;
          cd_cnt_d = CDW'(COOLDOWN_FRAMES);
          state_d  = COOLDOWN;
        end else if (bif.frame_tick) begin
          if (step_cnt_q == SCW'(STEP_FRAMES - 1)) begin
            step_cnt_d = '0;
            if (fl_off) begin
              // Retire at the edge; position keeps the last on-grid cell.
              valid_d  = 1'b0;
              cd_cnt_d = CDW'(COOLDOWN_FRAMES);
              state_d  = COOLDOWN;
            end else begin
              x_d = fl_x;
              y_d = fl_y;
            end
          end else begin
            step_cnt_d = step_cnt_q + SCW'(1);
          end
        end
      end
      COOLDOWN: begin
        if (bif.frame_tick) begin
          cd_cnt_d = cd_cnt_q - CDW'(1);
          if (cd_cnt_q == CDW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      step_cnt_q     <= '0;
      cd_cnt_q       <= '0;
      fire_pending_q <= 1'b0;
      valid_q        <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      dir_q          <= '0;
      ready_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      cd_cnt_q       <= cd_cnt_d;
      fire_pending_q <= fire_pending_d;
      valid_q        <= valid_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dir_q          <= dir_d;
      ready_q        <= ready_d;
    end
  end

  assign bif.bullet_valid = valid_q;
  assign bif.bullet_x     = x_q;
  assign bif.bullet_y     = y_q;
  assign bif.bullet_dir   = dir_q;
  assign bif.ready        = ready_q;
endmodule

// File: doc/tank_bullet.md
# tank_bullet

Single-bullet controller that sits directly downstream of the tank block. It consumes the tank's grid position and facing direction plus a player fire request, and launches one bullet from the cell in front of the tank. It advances the bullet on frame ticks and retires it on a collision report or at the playfield edge. Its registered bullet position and direction feed the Game collision logic and the VGA renderer.

## Interface
Parameters:
- X_MAX, 39: largest legal grid x (40×30 grid of 16-px tiles).
- Y_MAX, 29: largest legal grid y.
- STEP_FRAMES, 2: frame ticks per bullet cell move; ≥1.
- COOLDOWN_FRAMES, 8: frame ticks after retirement before the next fire is accepted; ≥1.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset: synchronous, active-high.
- frame_tick  in  1  one-cycle strobe per frame. This is the same strobe that drives the tank's valid_take_direction.
- fire  in  1  fire pulse or level, any cycle.
- tank_x  in  6  tank grid x.
- tank_y  in  6  tank grid y.
- tank_dir  in  2  tank facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- hit  in  1  from Game: bullet collided this cycle.
- bullet_valid  out  1  bullet on screen.
- bullet_x  out  6  bullet grid x.
- bullet_y  out  6  bullet grid y.
- bullet_dir  out  2  bullet travel direction.
- ready  out  1  high in IDLE, meaning a fire will be accepted.

## Operation
- **fire_pending:** sticky flag.
  - Set by fire on any cycle.
  - Cleared on every frame_tick, whether or not it was consumed.
  - Fire asserted in the same cycle as frame_tick counts as pending for that tick.
- **IDLE:** on frame_tick with pending:
  - Compute the spawn cell: the tank cell moved one step in tank_dir.
  - If the spawn cell is off-grid (x=0 & LEFT, x=X_MAX & RIGHT, y=0 & UP, y=Y_MAX & DOWN), the fire is dropped and the state stays IDLE.
  - Otherwise load bullet_x/y/dir, set bullet_valid, clear step_cnt, and go to FLYING.
- **FLYING:**
  - hit (any cycle) takes priority over everything. It clears bullet_valid, loads cd_cnt=COOLDOWN_FRAMES and goes to COOLDOWN. A frame_tick in the same cycle is ignored.
  - On frame_tick without hit: if step_cnt==STEP_FRAMES-1, step_cnt←0 and the bullet moves one cell in bullet_dir. Otherwise step_cnt increments.
  - If the next cell would be off-grid, the bullet retires instead of moving: bullet_valid←0, cd_cnt←COOLDOWN_FRAMES, COOLDOWN. bullet_x/y hold their last on-grid value.
- **COOLDOWN:** on frame_tick, if cd_cnt==1 go to IDLE, else cd_cnt decrements. hit is ignored.
- **hit while not FLYING:** ignored.
- **Arithmetic:** unsigned 6-bit. The bounds check precedes every ±1, so no wrap ever occurs.
- **Tank inputs:** sampled only at spawn. Later tank motion does not affect the bullet.

## Timing
- All outputs are registered and update the cycle after the triggering edge.
- Spawn is visible one cycle after the accepting frame_tick.
- Minimum fire-to-fire interval: time of flight + COOLDOWN_FRAMES ticks + 1 tick, since the IDLE accept needs a tick.
- Reset values: bullet_valid 0, bullet_x 0, bullet_y 0, bullet_dir 0, ready 1, state IDLE, step_cnt 0, cd_cnt 0, fire_pending 0.
- Reset mid-flight or mid-cooldown:
  - The bullet vanishes the next cycle.
  - A fire held across reset deassertion sets pending on the first cycle after reset.

## Structure
- **Shared package tank_pkg:**
  - Direction constants UP/DOWN/LEFT/RIGHT/STAND.
  - Default grid limits.
  - Bullet state enum {IDLE, FLYING, COOLDOWN}.
- **Sub-module grid_step:** combinational next-cell calculation.
  - Inputs: x, y, dir, X_MAX, Y_MAX.
  - Outputs: nx, ny, off_grid.
  - Instantiated twice, once for spawn and once for flight. Reusable by the tank later.

## Test plan
- **Spawn:** after reset, tank (10,10) RIGHT, fire + tick → next cycle valid=1, bullet (11,10), dir 3, ready=0.
- **Flight and edge retire:** STEP_FRAMES=2, spawn at (38,5) RIGHT. After tick 2 the bullet is at (39,5). After tick 4 valid=0, state COOLDOWN. After 8 more ticks ready=1.
- **Edge drop:** tank (0,7) LEFT, fire + tick → valid stays 0, ready stays 1, and no fire is retained after the tick.
- **Hit priority:** in FLYING, hit and frame_tick in the same cycle → valid=0, position unchanged. After exactly COOLDOWN_FRAMES further ticks, ready=1.
- **Fire latching:** fire pulse three cycles before a tick → spawn on that tick. Fire during COOLDOWN → no spawn after cooldown without a new fire.
- **Reset mid-flight:** rst for 1 cycle while FLYING → all outputs at reset values the next cycle.
